division_result_bcd: RTL and testbench
======================================

# division_result_bcd

Sequential binary-to-BCD converter sitting directly downstream of the divider. It captures the divider's 8-bit quotient and remainder on a start strobe and converts both to 3-digit packed BCD in parallel using shift-and-add-3 (double dabble), one bit per clock. It then presents the results with a one-cycle done pulse for the display/readout stage.

## Interface
Parameters:
- none; widths are fixed at 8-bit binary in and 12-bit (3-digit) BCD out.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  request conversion of the current quotient/remainder; sampled only in IDLE.
- quotient  input  8  unsigned binary quotient from the divider.
- remainder  input  8  unsigned binary remainder from the divider.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
- done  output  1  one-cycle pulse; q_bcd/r_bcd are valid and new in this cycle.
- q_bcd  output  12  packed BCD of quotient: [11:8] hundreds, [7:4] tens, [3:0] units.
- r_bcd  output  12  packed BCD of remainder, same packing.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: busy=0.
  - On start=1: latch quotient/remainder into internal 8-bit shift registers.
  - Clear both 12-bit BCD accumulators and the 3-bit bit counter; go to SHIFT.
- SHIFT, each cycle, per operand:
  - Add 3 to every accumulator digit ≥5, evaluating all three digits from pre-add values.
  - Shift {accumulator, shift register} left by 1.
  - Increment the counter.
  - After the 8th shift (counter was 7): load the final accumulators into q_bcd/r_bcd, set done=1, go to DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE with done=0.
- start while busy=1 (SHIFT or DONE) is ignored and not queued.
- Operands are sampled once at acceptance; input changes during SHIFT do not affect the result.
- Arithmetic:
  - Max input 255 yields 0x255, so no digit can overflow.
  - Hundreds digit never exceeds 2.
  - Output digits are always legal BCD (0–9).
- Reset mid-conversion: immediate return to IDLE; busy, done, q_bcd, r_bcd and all internal registers go to 0; the aborted conversion produces no done.

## Timing
- Reset values: busy=0, done=0, q_bcd=12'h000, r_bcd=12'h000.
- start accepted at edge N (state IDLE) → busy=1 from after edge N.
- Shifts occur on edges N+1 … N+8.
- q_bcd/r_bcd update and done=1 after edge N+8.
- done falls and state is IDLE after edge N+9; busy=0 from then.
- Latency start-edge to done: 8 cycles. Earliest next acceptance: edge N+10 (start must be high in IDLE). Minimum issue interval: 10 cycles.
- done and busy are registered outputs with no combinational path from inputs.

## Configuration
- DIVBCD_HOLD_EN defined:
  - q_bcd/r_bcd hold the last completed result through IDLE and the next conversion.
  - They change only at the edge that raises done.
- DIVBCD_HOLD_EN undefined:
  - q_bcd/r_bcd are cleared to 12'h000 at the edge that accepts start.
  - They stay 0 until the edge that raises done.
- done/busy timing is identical in both builds.

## Test plan
- Reset then idle: reset pulse, then 5 cycles with start=0 → busy=0, done=0, q_bcd=r_bcd=12'h000 throughout.
- Divider result 7/2: quotient=3, remainder=1, start for one cycle → done exactly 8 edges after acceptance; q_bcd=12'h003, r_bcd=12'h001; busy drops one cycle after done.
- Full range: quotient=255, remainder=200 → q_bcd=12'h255, r_bcd=12'h200. Then quotient=0, remainder=99 → q_bcd=12'h000, r_bcd=12'h099.
- Start while busy: start held high continuously with quotient=42, remainder=9 → conversions accepted every 10 cycles, done spacing 10 cycles. Operand changes mid-SHIFT are ignored: result stays 12'h042/12'h009.
- Reset mid-operation: assert reset asynchronously (between edges) 4 cycles after accepting quotient=128 → outputs 0 immediately, no done pulse. The next start with quotient=128 yields q_bcd=12'h128.
- Macro check: run 255 then 17 back-to-back in both builds. With DIVBCD_HOLD_EN, q_bcd stays 12'h255 until the second done, then becomes 12'h017. Without it, q_bcd is 12'h000 during the second conversion.

Source files
------------

// File: rtl/division_result_bcd.sv
// -----------------------------------------------------------------------------
// division_result_bcd
//
// Sequential binary-to-BCD converter for the divider's quotient and remainder.
// On a start strobe in IDLE both 8-bit operands are captured and converted in
// parallel with shift-and-add-3 (double dabble), one bit per clock. Eight
// shifts later the 3-digit packed BCD results are published together with a
// one-cycle done pulse.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state and outputs
//   start      in   1   conversion request, sampled only in IDLE
//   quotient   in   8   unsigned binary quotient
//   remainder  in   8   unsigned binary remainder
//   busy       out  1   high in SHIFT and DONE
//   done       out  1   one-cycle pulse; q_bcd/r_bcd are new in this cycle
//   q_bcd      out  12  quotient BCD:  [11:8] hundreds, [7:4] tens, [3:0] units
//   r_bcd      out  12  remainder BCD, same packing
//
// Configuration macro:
//   DIVBCD_HOLD_EN  defined   -> q_bcd/r_bcd hold the last result until the
//                                edge that raises the next done.
//                   undefined -> q_bcd/r_bcd clear at the edge that accepts
//                                start and stay 0 until done.
// -----------------------------------------------------------------------------
module division_result_bcd (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  quotient,
  input  logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic [11:0] q_bcd,
  output logic [11:0] r_bcd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  q_sr;
  logic [7:0]  r_sr;
  logic [11:0] q_acc;
  logic [11:0] r_acc;
  logic [2:0]  bit_cnt;

  logic [11:0] q_next;
  logic [11:0] r_next;

  // One double-dabble step: every digit >= 5 gets +3 (all decided from the
  // pre-add accumulator), then the accumulator shifts left taking in the
  // next binary bit. With 8-bit input the hundreds digit never exceeds 2,
  // so the bit shifted out of the top is always 0.
  function automatic logic [11:0] dabble_step(input logic [11:0] acc,
                                              input logic        in_bit);
    logic [11:0] adj;
    adj = acc;
    for (int d = 0; d < 3; d++) begin
      if (acc[d*4 +: 4] >= 4'd5)
        adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
    end
    return {adj[10:0], in_bit};
  endfunction

  always_comb begin
    q_next = dabble_step(q_acc, q_sr[7]);
    r_next = dabble_step(r_acc, r_sr[7]);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      q_sr    <= '0;
      r_sr    <= '0;
      q_acc   <= '0;
      r_acc   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q_bcd   <= '0;
      r_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_sr    <= quotient;
            r_sr    <= remainder;
            q_acc   <= '0;
            r_acc   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
`ifndef DIVBCD_HOLD_EN
            q_bcd   <= '0;
            r_bcd   <= '0;
`endif
          end
        end

        SHIFT: begin
          q_acc   <= q_next;
          r_acc   <= r_next;
          q_sr    <= {q_sr[6:0], 1'b0};
          r_sr    <= {r_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          // Counter at 7 means this edge performs the eighth and final shift.
          if (bit_cnt == 3'd7) begin
            q_bcd <= q_next;
            r_bcd <= r_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_division_result_bcd
//
// Scoreboard bench for division_result_bcd. Stimulus pushes the hand-computed
// BCD results and the cycle at which done must appear; an independent monitor
// pops and compares on every done pulse and also checks that done is a single
// cycle and busy falls right after it.
// -----------------------------------------------------------------------------
module tb_division_result_bcd;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;

  division_result_bcd dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (prev_done) begin
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q_bcd", {20'd0, q_bcd}, {20'd0, e.q});
        check("r_bcd", {20'd0, r_bcd}, {20'd0, e.r});
        check("done_latency", cyc, e.cyc);
        check("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
    prev_done = done;
  end

  // Present operands, strobe start for one cycle, record expected result.
  task automatic issue(input logic [7:0] q, input logic [7:0] r,
                       input logic [11:0] eq, input logic [11:0] er);
    exp_t e;
    @(negedge clock);
    quotient  = q;
    remainder = r;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e.q   = eq;
    e.r   = er;
    e.cyc = cyc + 8;
    sb.push_back(e);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    reset     = 1'b1;
    start     = 1'b0;
    quotient  = 8'd0;
    remainder = 8'd0;
    #12;
    check("reset_q", {20'd0, q_bcd}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_outputs", {busy, done, q_bcd, r_bcd}, 32'd0);
    end

    // 7 / 2 -> quotient 3, remainder 1.
    issue(8'd3, 8'd1, 12'h003, 12'h001);
    repeat (12) @(posedge clock);

    // Full range and zero quotient.
    issue(8'd255, 8'd200, 12'h255, 12'h200);
    repeat (10) @(posedge clock);
    issue(8'd0, 8'd99, 12'h000, 12'h099);
    repeat (12) @(posedge clock);

    // Start held high: accepts every 10 cycles; mid-SHIFT operand changes ignored.
    @(negedge clock);
    quotient  = 8'd42;
    remainder = 8'd9;
    start     = 1'b1;
    @(posedge clock);
    #1;
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      e.q   = 12'h042;
      e.r   = 12'h009;
      e.cyc = n + 8 + 10 * k;
      sb.push_back(e);
    end
    repeat (3) @(posedge clock);
    #1;
    quotient  = 8'd99;
    remainder = 8'd77;
    check("busy_mid_shift", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    quotient  = 8'd42;
    remainder = 8'd9;
    repeat (14) @(posedge clock);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clock);

    // Reset asserted between edges four cycles into a conversion.
    @(negedge clock);
    quotient  = 8'd128;
    remainder = 8'd5;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, done, q_bcd, r_bcd}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(posedge clock);
    check("no_done_after_abort", sb.size(), 32'd0);
    issue(8'd128, 8'd5, 12'h128, 12'h005);
    repeat (12) @(posedge clock);

    // Back-to-back 255 then 17: output behaviour during the second conversion.
    issue(8'd255, 8'd0, 12'h255, 12'h000);
    repeat (9) @(posedge clock);
    #1;
    check("idle_holds_result", {20'd0, q_bcd}, 32'h255);
    issue(8'd17, 8'd3, 12'h017, 12'h003);
    repeat (3) @(negedge clock);
`ifdef DIVBCD_HOLD_EN
    check("q_during_second", {20'd0, q_bcd}, 32'h255);
`else
    check("q_during_second", {20'd0, q_bcd}, 32'h000);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
